// File: rtl/big_core_vga_char_writer.sv
// Text-mode character writer: 8x8 glyph lookup, two 32-bit tile writes into VGA memory.
// Optional cursor mode via `VGA_CHAR_CURSOR_EN (auto-advancing cursor, newline handling).
module big_core_vga_char_writer #(
  parameter logic [31:0] VGA_MEM_BASE = 32'h0000_0000,
  parameter int          NUM_COLS     = 80,
  parameter int          NUM_ROWS     = 60
) (
  input  logic        Clk_50,
  input  logic        Reset,
  input  logic        CharValid,
  output logic        CharReady,
  input  logic [7:0]  CharCode,
  input  logic [6:0]  CharCol,
  input  logic [5:0]  CharRow,
  output logic        VgaWrReq,
  input  logic        VgaWrGnt,
  output logic [31:0] VgaWrAddr,
  output logic [31:0] VgaWrData,
  output logic [3:0]  VgaWrByteEn,
  output logic        CharDone,
  output logic        CharErr,
  output logic [6:0]  CursorCol,
  output logic [5:0]  CursorRow
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WR_TOP = 2'd1;
  localparam logic [1:0] WR_BOT = 2'd2;

  localparam logic [6:0]  COLS_W = 7'(NUM_COLS);
  localparam logic [5:0]  ROWS_W = 6'(NUM_ROWS);
  localparam logic [13:0] BAND   = 14'(NUM_COLS);
  localparam logic [13:0] ROW_WORDS = 14'(2 * NUM_COLS);

  logic [1:0]  state;
  logic [31:0] bot_addr;
  logic [31:0] bot_data;
  logic [6:0]  pos_col;
  logic [5:0]  pos_row;
  logic        in_range;
  logic        is_nl;
  logic [13:0] top_idx;
  logic [13:0] bot_idx;
  logic [63:0] glyph;

  // Glyph rows in reading order: row 0 in bits [63:56], row 7 in [7:0]. Bit 0 = leftmost pixel.
  function automatic logic [63:0] font_rows(input logic [7:0] code);
    case (code)
      8'h20:   font_rows = 64'h0000000000000000;
      8'h30:   font_rows = 64'h3C666E7666663C00;
      8'h31:   font_rows = 64'h181C181818187E00;
      8'h32:   font_rows = 64'h3C6660300C067E00;
      8'h33:   font_rows = 64'h3C66603860663C00;
      8'h34:   font_rows = 64'h303834327E303000;
      8'h35:   font_rows = 64'h7E063E6060663C00;
      8'h36:   font_rows = 64'h3C063E6666663C00;
      8'h37:   font_rows = 64'h7E6030180C0C0C00;
      8'h38:   font_rows = 64'h3C66663C66663C00;
      8'h39:   font_rows = 64'h3C66667C60301C00;
      8'h41:   font_rows = 64'h183C66667E666600;
      8'h42:   font_rows = 64'h3E66663E66663E00;
      8'h43:   font_rows = 64'h3C66060606663C00;
      8'h44:   font_rows = 64'h1E36666666361E00;
      8'h45:   font_rows = 64'h7E06063E06067E00;
      8'h46:   font_rows = 64'h7E06063E06060600;
      default: font_rows = 64'hFFFFFFFFFFFFFFFF;
    endcase
  endfunction

  // Tile word: byte k holds glyph row (first + k).
  function automatic logic [31:0] top_word(input logic [63:0] g);
    top_word = {g[39:32], g[47:40], g[55:48], g[63:56]};
  endfunction

  function automatic logic [31:0] bot_word(input logic [63:0] g);
    bot_word = {g[7:0], g[15:8], g[23:16], g[31:24]};
  endfunction

  function automatic logic [31:0] word_addr(input logic [13:0] idx);
    word_addr = VGA_MEM_BASE + {16'd0, idx, 2'b00};
  endfunction

`ifdef VGA_CHAR_CURSOR_EN
  logic [6:0] cur_col;
  logic [5:0] cur_row;
  logic       adv;
  logic       nl_take;

  assign is_nl    = (CharCode == 8'h0A);
  assign pos_col  = cur_col;
  assign pos_row  = cur_row;
  assign in_range = 1'b1;
  assign adv      = (state == WR_BOT) && VgaWrGnt;
  assign nl_take  = (state == IDLE) && CharValid && is_nl;

  always_ff @(posedge Clk_50 or posedge Reset) begin
    if (Reset) begin
      cur_col <= '0;
      cur_row <= '0;
    end else if (nl_take || (adv && cur_col == COLS_W - 7'd1)) begin
      cur_col <= '0;
      cur_row <= (cur_row == ROWS_W - 6'd1) ? 6'd0 : cur_row + 6'd1;
    end else if (adv) begin
      cur_col <= cur_col + 7'd1;
    end
  end

  assign CursorCol = cur_col;
  assign CursorRow = cur_row;
`else
  assign is_nl     = 1'b0;
  assign pos_col   = CharCol;
  assign pos_row   = CharRow;
  assign in_range  = (CharCol < COLS_W) && (CharRow < ROWS_W);
  assign CursorCol = '0;
  assign CursorRow = '0;
`endif

  assign glyph     = font_rows(CharCode);
  assign top_idx   = 14'(pos_row) * ROW_WORDS + 14'(pos_col);
  assign bot_idx   = top_idx + BAND;
  assign CharReady = (state == IDLE);

  // Outputs are registered so they stay stable while the port withholds the grant.
  always_ff @(posedge Clk_50 or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      VgaWrReq    <= 1'b0;
      VgaWrAddr   <= '0;
      VgaWrData   <= '0;
      VgaWrByteEn <= '0;
      CharDone    <= 1'b0;
      CharErr     <= 1'b0;
      bot_addr    <= '0;
      bot_data    <= '0;
    end else begin
      CharDone <= 1'b0;
      CharErr  <= 1'b0;
      case (state)
        IDLE: begin
          if (CharValid) begin
            if (is_nl) begin
              CharDone <= 1'b1;
            end else if (!in_range) begin
              CharErr <= 1'b1;
            end else begin
              state       <= WR_TOP;
              VgaWrReq    <= 1'b1;
              VgaWrAddr   <= word_addr(top_idx);
              VgaWrData   <= top_word(glyph);
              VgaWrByteEn <= 4'hF;
              bot_addr    <= word_addr(bot_idx);
              bot_data    <= bot_word(glyph);
            end
          end
        end
        WR_TOP: begin
          if (VgaWrGnt) begin
            state     <= WR_BOT;
            VgaWrAddr <= bot_addr;
            VgaWrData <= bot_data;
          end
        end
        WR_BOT: begin
          if (VgaWrGnt) begin
            state       <= IDLE;
            VgaWrReq    <= 1'b0;
            VgaWrByteEn <= 4'h0;
            CharDone    <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          VgaWrReq <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_big_core_vga_char_writer.sv
// Bench for big_core_vga_char_writer: font/address model with a per-cycle write-port checker
// plus directed literal checks (cursor scenarios when VGA_CHAR_CURSOR_EN is defined).
module tb_big_core_vga_char_writer;
  logic        Clk_50 = 1'b0;
  logic        Reset = 1'b1;
  logic        CharValid = 1'b0;
  logic        CharReady;
  logic [7:0]  CharCode = 8'h00;
  logic [6:0]  CharCol = 7'd0;
  logic [5:0]  CharRow = 6'd0;
  logic        VgaWrReq;
  logic        VgaWrGnt = 1'b1;
  logic [31:0] VgaWrAddr;
  logic [31:0] VgaWrData;
  logic [3:0]  VgaWrByteEn;
  logic        CharDone;
  logic        CharErr;
  logic [6:0]  CursorCol;
  logic [5:0]  CursorRow;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_addr [0:1023];
  logic [31:0] exp_data [0:1023];
  int wr_idx = 0;
  int rd_idx = 0;
  int xfer_cnt = 0;
  logic [63:0] font [0:255];
  int cur_col = 0;
  int cur_row = 0;

  always #10 Clk_50 = ~Clk_50;

  big_core_vga_char_writer dut (
    .Clk_50(Clk_50), .Reset(Reset), .CharValid(CharValid), .CharReady(CharReady),
    .CharCode(CharCode), .CharCol(CharCol), .CharRow(CharRow),
    .VgaWrReq(VgaWrReq), .VgaWrGnt(VgaWrGnt), .VgaWrAddr(VgaWrAddr), .VgaWrData(VgaWrData),
    .VgaWrByteEn(VgaWrByteEn), .CharDone(CharDone), .CharErr(CharErr),
    .CursorCol(CursorCol), .CursorRow(CursorRow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Tile word built from glyph rows first..first+3, row n stored in byte (n - first).
  function automatic logic [31:0] tile(input logic [63:0] rows, input int first);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = rows[63 - 8*(first + k) -: 8];
    return w;
  endfunction

  task automatic expect_glyph(input logic [7:0] code, input int col, input int row);
    int idx;
    idx = row * 2 * 80 + col;
    exp_addr[wr_idx % 1024] = 32'(idx * 4);
    exp_data[wr_idx % 1024] = tile(font[code], 0);
    wr_idx++;
    exp_addr[wr_idx % 1024] = 32'((idx + 80) * 4);
    exp_data[wr_idx % 1024] = tile(font[code], 4);
    wr_idx++;
  endtask

  // Drive at a negedge, accept on the next posedge, return at the following negedge.
  task automatic send_char(input logic [7:0] code, input int col, input int row);
    int n;
    n = 0;
    CharValid = 1'b1;
    CharCode  = code;
    CharCol   = 7'(col);
    CharRow   = 6'(row);
    while (!CharReady && n < 50) begin
      @(negedge Clk_50);
      n++;
    end
    if (!CharReady) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: got CharReady=0, expected 1 within 50 cycles");
    end else begin
`ifdef VGA_CHAR_CURSOR_EN
      if (code == 8'h0A) begin
        cur_col = 0;
        cur_row = (cur_row == 59) ? 0 : cur_row + 1;
      end else begin
        expect_glyph(code, cur_col, cur_row);
        if (cur_col == 79) begin
          cur_col = 0;
          cur_row = (cur_row == 59) ? 0 : cur_row + 1;
        end else cur_col = cur_col + 1;
      end
`else
      if (col < 80 && row < 60) expect_glyph(code, col, row);
`endif
    end
    @(posedge Clk_50);
    @(negedge Clk_50);
    CharValid = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge Clk_50);
  endtask

  initial begin
    int base;
    logic p_req;
    logic p_gnt;
    p_req = 1'b0;
    p_gnt = 1'b0;
    for (int c = 0; c < 256; c++) font[c] = 64'hFFFFFFFFFFFFFFFF;
    font[8'h20] = 64'h0;
    font[8'h30] = 64'h3C666E7666663C00; font[8'h31] = 64'h181C181818187E00;
    font[8'h32] = 64'h3C6660300C067E00; font[8'h33] = 64'h3C66603860663C00;
    font[8'h34] = 64'h303834327E303000; font[8'h35] = 64'h7E063E6060663C00;
    font[8'h36] = 64'h3C063E6666663C00; font[8'h37] = 64'h7E6030180C0C0C00;
    font[8'h38] = 64'h3C66663C66663C00; font[8'h39] = 64'h3C66667C60301C00;
    font[8'h41] = 64'h183C66667E666600; font[8'h42] = 64'h3E66663E66663E00;
    font[8'h43] = 64'h3C66060606663C00; font[8'h44] = 64'h1E36666666361E00;
    font[8'h45] = 64'h7E06063E06067E00; font[8'h46] = 64'h7E06063E06060600;

    fork
      // Write-port checker: every requesting cycle must present the oldest expected word.
      forever begin
        @(negedge Clk_50);
        #1;
        if (Reset) begin
          rd_idx = wr_idx;
          p_req = 1'b0;
          p_gnt = 1'b0;
        end else begin
          if (p_req && !p_gnt && !VgaWrReq) chk("req_dropped", 32'(VgaWrReq), 32'd1);
          if (VgaWrReq) begin
            if (rd_idx == wr_idx) begin
              chk("unexpected_req", 32'(VgaWrReq), 32'd0);
            end else begin
              chk("wr_addr", VgaWrAddr, exp_addr[rd_idx % 1024]);
              chk("wr_data", VgaWrData, exp_data[rd_idx % 1024]);
              chk("wr_be", 32'(VgaWrByteEn), 32'hF);
              if (VgaWrGnt) begin
                rd_idx++;
                xfer_cnt++;
              end
            end
          end
          p_req = VgaWrReq;
          p_gnt = VgaWrGnt;
        end
      end
    join_none

    cycles(2);
    chk("rst_ready", 32'(CharReady), 32'd1);
    chk("rst_req", 32'(VgaWrReq), 32'd0);
    chk("rst_addr", VgaWrAddr, 32'd0);
    chk("rst_data", VgaWrData, 32'd0);
    chk("rst_be", 32'(VgaWrByteEn), 32'd0);
    chk("rst_done", 32'(CharDone), 32'd0);
    chk("rst_err", 32'(CharErr), 32'd0);
    chk("rst_ccol", 32'(CursorCol), 32'd0);
    chk("rst_crow", 32'(CursorRow), 32'd0);
    Reset = 1'b0;
    cycles(1);

`ifdef VGA_CHAR_CURSOR_EN
    for (int i = 0; i < 81; i++) begin
      send_char(8'h20, 0, 0);
      if (i == 80) chk("cur_81st_addr", VgaWrAddr, 32'h0000_0280);
    end
    cycles(3);
    chk("cur_col_after81", 32'(CursorCol), 32'd1);
    chk("cur_row_after81", 32'(CursorRow), 32'd1);
    send_char(8'h0A, 0, 0);
    chk("nl_done", 32'(CharDone), 32'd1);
    chk("nl_req", 32'(VgaWrReq), 32'd0);
    chk("nl_col", 32'(CursorCol), 32'd0);
    chk("nl_row", 32'(CursorRow), 32'd2);
    send_char(8'h31, 90, 70);
    chk("cur_top_addr", VgaWrAddr, 32'h0000_0500);
    chk("cur_top_data", VgaWrData, 32'h18181C18);
    cycles(3);
    chk("cur_err_never", 32'(CharErr), 32'd0);
`else
    send_char(8'h20, 0, 0);
    chk("sp_top_req", 32'(VgaWrReq), 32'd1);
    chk("sp_top_addr", VgaWrAddr, 32'h0000_0000);
    chk("sp_top_data", VgaWrData, 32'h0);
    chk("sp_top_be", 32'(VgaWrByteEn), 32'hF);
    chk("sp_busy", 32'(CharReady), 32'd0);
    cycles(1);
    chk("sp_bot_addr", VgaWrAddr, 32'h0000_0140);
    chk("sp_done_early", 32'(CharDone), 32'd0);
    cycles(1);
    chk("sp_done", 32'(CharDone), 32'd1);
    chk("sp_ready", 32'(CharReady), 32'd1);
    chk("sp_req_off", 32'(VgaWrReq), 32'd0);
    cycles(1);
    chk("sp_done_pulse", 32'(CharDone), 32'd0);

    send_char(8'h7E, 79, 59);
    chk("blk_top_addr", VgaWrAddr, 32'h0000_94BC);
    chk("blk_top_data", VgaWrData, 32'hFFFF_FFFF);
    cycles(1);
    chk("blk_bot_addr", VgaWrAddr, 32'h0000_95FC);
    chk("blk_bot_data", VgaWrData, 32'hFFFF_FFFF);
    cycles(1);

    send_char(8'h31, 5, 2);
    chk("one_top_addr", VgaWrAddr, 32'h0000_0514);
    chk("one_top_data", VgaWrData, 32'h18181C18);
    cycles(1);
    chk("one_bot_data", VgaWrData, 32'h007E1818);
    cycles(1);
    send_char(8'h30, 0, 1);
    send_char(8'h41, 40, 30);
    send_char(8'h46, 79, 0);
    send_char(8'h39, 1, 59);
    send_char(8'h42, 12, 7);
    send_char(8'h0A, 3, 3);
    cycles(3);

    send_char(8'h41, 80, 0);
    chk("col_err", 32'(CharErr), 32'd1);
    chk("col_err_req", 32'(VgaWrReq), 32'd0);
    chk("col_err_ready", 32'(CharReady), 32'd1);
    cycles(1);
    chk("col_err_pulse", 32'(CharErr), 32'd0);
    chk("col_err_noreq", 32'(VgaWrReq), 32'd0);
    send_char(8'h41, 0, 60);
    chk("row_err", 32'(CharErr), 32'd1);
    cycles(1);
    chk("row_err_pulse", 32'(CharErr), 32'd0);
`endif

    // Grant withheld for five cycles in WR_TOP.
    VgaWrGnt = 1'b0;
    base = xfer_cnt;
    send_char(8'h33, 10, 10);
    for (int i = 0; i < 5; i++) begin
      chk("stall_req", 32'(VgaWrReq), 32'd1);
      chk("stall_addr", VgaWrAddr, exp_addr[(wr_idx - 2) % 1024]);
      chk("stall_data", VgaWrData, exp_data[(wr_idx - 2) % 1024]);
      @(negedge Clk_50);
    end
    VgaWrGnt = 1'b1;
    cycles(4);
    chk("stall_xfers", 32'(xfer_cnt - base), 32'd2);

    // Reset while stalled in WR_BOT.
    send_char(8'h34, 20, 20);
    @(negedge Clk_50);
    VgaWrGnt = 1'b0;
    chk("bot_pending", 32'(VgaWrReq), 32'd1);
    @(negedge Clk_50);
    Reset = 1'b1;
    cur_col = 0;
    cur_row = 0;
    #1;
    chk("rst_mid_req", 32'(VgaWrReq), 32'd0);
    chk("rst_mid_ready", 32'(CharReady), 32'd1);
    @(negedge Clk_50);
    Reset = 1'b0;
    VgaWrGnt = 1'b1;
    cycles(2);
    chk("post_rst_ready", 32'(CharReady), 32'd1);
    chk("post_rst_req", 32'(VgaWrReq), 32'd0);
    send_char(8'h45, 2, 0);
    cycles(4);
    chk("all_written", 32'(rd_idx), 32'(wr_idx));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/big_core_vga_char_writer.md
Name: big_core_vga_char_writer

Overview:
Text-mode front end for the VGA frame buffer. It accepts one ASCII character per handshake, looks up an 8x8 glyph and writes it into VGA memory as two 32-bit words through the memory's write port. It sits directly upstream of the VGA controller's memory write port and shares that port with the core through a request/grant pair. Frame-buffer layout: each word is an 8-pixel x 4-line tile; byte k holds line k of the tile; bit j is pixel j, with bit 0 the leftmost pixel. There are 80 words per 4-line band.

Parameters:
VGA_MEM_BASE, 32'h0000_0000, byte base address of VGA memory in the core address map
NUM_COLS, 80, character columns (8 px each)
NUM_ROWS, 60, character rows (8 lines each)

Ports:
Clk_50  input  1  clock
Reset  input  1  asynchronous active-high reset
CharValid  input  1  character request valid
CharReady  output  1  block can accept a character
CharCode  input  8  ASCII code
CharCol  input  7  target column 0..79
CharRow  input  6  target row 0..59
VgaWrReq  output  1  write request to VGA memory port
VgaWrGnt  input  1  write granted this cycle
VgaWrAddr  output  32  byte address, word aligned
VgaWrData  output  32  write data
VgaWrByteEn  output  4  byte enables
CharDone  output  1  one-cycle pulse: glyph fully written
CharErr  output  1  one-cycle pulse: position out of range, character dropped
CursorCol  output  7  current cursor column
CursorRow  output  6  current cursor row

Behaviour:
- One clock, Clk_50. Reset is asynchronous and active-high; all state is cleared on its assertion.
- Reset values: state IDLE; CharReady=1; VgaWrReq=0; VgaWrAddr=0; VgaWrData=0; VgaWrByteEn=0; CharDone=0; CharErr=0; CursorCol=0; CursorRow=0.
- FSM states: IDLE, WR_TOP, WR_BOT.
- IDLE: CharReady=1. A character is accepted when CharValid & CharReady.
  - Accepted and in range: latch the glyph (8 rows g0..g7) and the position; go to WR_TOP.
  - Accepted and CharCol>=NUM_COLS or CharRow>=NUM_ROWS: pulse CharErr the next cycle; stay in IDLE; no write is issued.
- WR_TOP: CharReady=0; VgaWrReq=1.
  - Word index = CharRow*160 + CharCol.
  - VgaWrAddr = VGA_MEM_BASE + index*4.
  - VgaWrData = {g3,g2,g1,g0}; VgaWrByteEn=4'hF.
  - On VgaWrGnt go to WR_BOT.
- WR_BOT: same as WR_TOP, except word index = CharRow*160 + 80 + CharCol and VgaWrData = {g7,g6,g5,g4}.
  - On VgaWrGnt go to IDLE, and pulse CharDone the next cycle.
- Write handshake: a transfer occurs on a cycle with VgaWrReq & VgaWrGnt. While VgaWrReq=1 and VgaWrGnt=0, address, data and byte enables are held stable. VgaWrReq never drops without a grant, except on Reset.
- Latency with VgaWrGnt tied high:
  - Character accepted at edge N.
  - Top word written in cycle N+1, bottom word in cycle N+2.
  - CharReady=1 and CharDone=1 in cycle N+3.
  - Throughput is one character per 3 cycles.
- Index arithmetic is done at 14 bits (maximum index 9599); the address add is 32-bit with wrap and no overflow check.
- Font table, fixed in the module:
  - 0x20 (space): all rows 0.
  - 0x30-0x39 and 0x41-0x46: the team hex-digit glyphs.
  - Any other code: all rows 8'hFF (solid block).
- Reset mid-operation: VgaWrReq drops immediately (asynchronously); a partially written glyph is left in memory.
- Without the cursor feature, CursorCol and CursorRow stay 0.

Optional Feature:
Macro: VGA_CHAR_CURSOR_EN
- Defined:
  - CharCol and CharRow are ignored; the glyph is written at CursorCol/CursorRow. CharErr never fires.
  - After each CharDone: CursorCol+1. When CursorCol reaches 79 it wraps to 0 and CursorRow+1; CursorRow wraps from 59 to 0.
  - Code 0x0A (newline) writes nothing: CursorCol=0, CursorRow+1 with the same wrap, CharDone pulses the next cycle.
- Not defined: behaviour exactly as in Behaviour, with cursor outputs tied to 0.

Test Plan:
- Space at col 0, row 0, VgaWrGnt=1 -> writes addr 0x0000 data 0x0 and addr 0x0140 data 0x0, byte enables 4'hF; CharDone 3 cycles after accept.
- Code 0x7E at col 79, row 59 -> writes addr 0x94BC data 0xFFFFFFFF and addr 0x95FC data 0xFFFFFFFF.
- Col 80, row 0 -> no VgaWrReq; CharErr pulses once; CharReady=1 the next cycle.
- VgaWrGnt held low 5 cycles during WR_TOP -> VgaWrReq, VgaWrAddr and VgaWrData stable all 5 cycles; exactly 2 transfers total after the grant.
- Reset asserted in WR_BOT -> VgaWrReq=0 immediately; after release, state IDLE and CharReady=1.
- VGA_CHAR_CURSOR_EN defined: 81 spaces -> 81st top write at addr 0x0280 (col 0, row 1); then 0x0A -> CursorCol=0, CursorRow=2, no write.
